esc_frame_sequencer: RTL
========================

Name: esc_frame_sequencer

Overview:
- Sequences the four ESC PWM generators (front, back, left, right) from one shared frame timer.
- Issues the shared wrt pulse once per frame and owns the arm/disarm state machine.
- Latches setpoints from the flight controller and slew-limits them per frame.
- Forces zero throttle on disarm or on stale setpoints (failsafe).
- Sits between the flight controller and the four ESC PWM blocks; its speed outputs drive their SPEED inputs directly.

Parameters:
FRAME_CYCLES, 50000, clocks per PWM frame (1 kHz at 50 MHz); must exceed the longest pulse, 12391 clocks.
ARM_FRAMES, 64, consecutive frames of forced zero throttle in ARMING before RUN.
TIMEOUT_FRAMES, 8, consecutive frame edges without spd_vld in RUN that trigger FAILSAFE.
MAX_STEP, 128, maximum per-frame change of any speed output (11-bit units).

Ports:
clk  in  1  system clock
rst_n  in  1  reset
arm  in  1  level; 1 = request motors armed
spd_vld  in  1  one-cycle strobe; new setpoints valid on the four *_spd inputs
frnt_spd  in  11  front motor setpoint
bck_spd  in  11  back motor setpoint
lft_spd  in  11  left motor setpoint
rght_spd  in  11  right motor setpoint
frnt_out  out  11  front speed to ESC
bck_out  out  11  back speed to ESC
lft_out  out  11  left speed to ESC
rght_out  out  11  right speed to ESC
wrt  out  1  shared one-cycle frame strobe to all ESCs
armed  out  1  1 while in RUN
failsafe  out  1  1 while in FAILSAFE

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk, rising edge. Reset clears all state.
- Reset values: all *_out = 0, wrt = 0, armed = 0, failsafe = 0, state DISARMED, frame counter 0, setpoints 0, arm and timeout counters 0.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1, then wraps to 0.
  - The "frame edge" is the clock edge on which it wraps.
  - Width is clog2(FRAME_CYCLES).
- wrt:
  - Registered; high for exactly the cycle in which the frame counter equals 1.
  - First wrt is therefore cycle 1 after reset release, then every FRAME_CYCLES.
  - wrt is generated in every state, so ESCs always receive pulses.
  - *_out change only on frame edges, so they are stable for at least one cycle before and during wrt.
- Setpoint latch:
  - On any cycle with spd_vld=1, all four inputs are captured into setpoint registers in every state.
  - A capture on the frame-edge cycle takes effect at the next frame edge; slew uses the old setpoint.
- Slew rule, RUN only, per motor at each frame edge:
  - If |sp - out| <= MAX_STEP, then out = sp.
  - Otherwise out moves toward sp by MAX_STEP.
  - Unsigned arithmetic with a 12-bit difference; the result never leaves 0..2047.
- States and transitions; all are evaluated only at frame edges except arm deassertion.
  - DISARMED: outputs 0. A frame edge with arm=1 -> ARMING, arm counter = 0.
  - ARMING: outputs 0; arm counter +1 per frame edge. When the counter reaches ARM_FRAMES -> RUN, timeout counter = 0.
  - RUN: armed=1; slew applied each frame edge; timeout counter +1 per frame edge. The counter reaches TIMEOUT_FRAMES -> FAILSAFE.
  - FAILSAFE: failsafe=1; outputs forced to 0 on the entering frame edge. spd_vld does not recover; only arm=0 leaves it.
  - From ARMING, RUN or FAILSAFE: arm=0 sampled on any cycle -> DISARMED next cycle. *_out become 0 on that same edge, outside the frame-edge rule; this is a safety override.
- Timeout counter:
  - Cleared by spd_vld.
  - If spd_vld and a frame edge coincide, clear wins: counter = 0, no FAILSAFE on that edge.
- Outputs are zero on entry to RUN and ramp up via slew.
- Async reset mid-frame: everything returns to reset values immediately, and frame timing restarts from counter 0.

Test Plan:
Bench parameters: FRAME_CYCLES=100, ARM_FRAMES=4, TIMEOUT_FRAMES=3, MAX_STEP=128.
- Reset release, arm=0 -> wrt high at cycles 1, 101, 201; all *_out=0; armed=0, failsafe=0.
- arm=1 at cycle 50, spd_vld every frame with all setpoints 500 -> armed=1 after the 4th frame edge; next frame edges give *_out 128, 256, 384, 500, 500.
- In RUN at 500, setpoints step to 100 and frnt_spd to 2047 -> others 372, 244, 116, 100; frnt 628, 756, ... reaching 2047 with no wrap.
- Stop spd_vld in RUN -> failsafe=1 and *_out=0 on the 3rd frame edge; later spd_vld keeps failsafe; arm=0 gives DISARMED next cycle, then rearming needs 4 frames.
- arm dropped after 2 ARMING frames -> DISARMED, outputs 0; re-arm restarts the count at 0, so RUN needs 4 more frames. Separately, spd_vld on the frame-edge cycle with timeout=2 -> no failsafe.
- rst_n asserted mid-frame while in RUN at 500 -> *_out=0, wrt=0, armed=0 immediately; after release, wrt at cycle 1.

Source files
------------

// File: rtl/esc_frame_sequencer.sv
// Frame timer, arm/disarm/failsafe sequencing and per-frame slew limiting
// for the four ESC PWM generators.
module esc_frame_sequencer #(
    parameter int FRAME_CYCLES   = 50000,
    parameter int ARM_FRAMES     = 64,
    parameter int TIMEOUT_FRAMES = 8,
    parameter int MAX_STEP       = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        spd_vld,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic [10:0] frnt_out,
    output logic [10:0] bck_out,
    output logic [10:0] lft_out,
    output logic [10:0] rght_out,
    output logic        wrt,
    output logic        armed,
    output logic        failsafe
);

    localparam int FW = $clog2(FRAME_CYCLES);
    localparam int AW = $clog2(ARM_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [11:0] STEP = 12'(MAX_STEP);

    typedef enum logic [1:0] {DISARMED, ARMING, RUN, FAILSAFE} state_t;

    state_t             state, state_nxt;
    logic [FW-1:0]      frame_cnt;
    logic               frame_edge;
    logic [AW-1:0]      arm_cnt, arm_cnt_nxt;
    logic [TW-1:0]      to_cnt, to_cnt_nxt;
    logic [3:0][10:0]   sp_q;
    logic [3:0][10:0]   out_q, out_nxt;

    assign frame_edge = (frame_cnt == FW'(FRAME_CYCLES - 1));

    function automatic logic [10:0] slew(input logic [10:0] cur, input logic [10:0] tgt);
        logic [11:0] diff;
        logic [10:0] res;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            res  = (diff <= STEP) ? tgt : cur + STEP[10:0];
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
            res  = (diff <= STEP) ? tgt : cur - STEP[10:0];
        end
        return res;
    endfunction

    // wrt is registered from counter==0 so it is high while the counter reads 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            wrt       <= 1'b0;
        end else begin
            frame_cnt <= frame_edge ? '0 : frame_cnt + 1'b1;
            wrt       <= (frame_cnt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (spd_vld) begin
            sp_q <= {rght_spd, lft_spd, bck_spd, frnt_spd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DISARMED;
            arm_cnt <= '0;
            to_cnt  <= '0;
            out_q   <= '0;
        end else begin
            state   <= state_nxt;
            arm_cnt <= arm_cnt_nxt;
            to_cnt  <= to_cnt_nxt;
            out_q   <= out_nxt;
        end
    end

    // arm=0 overrides the frame-edge rule: disarm and zero outputs on the next edge
    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        to_cnt_nxt  = spd_vld ? '0 : to_cnt;
        out_nxt     = out_q;
        case (state)
            DISARMED: begin
                out_nxt = '0;
                if (frame_edge && arm) begin
                    state_nxt   = ARMING;
                    arm_cnt_nxt = '0;
                end
            end
            ARMING: begin
                out_nxt = '0;
                if (!arm) begin
                    state_nxt = DISARMED;
                end else if (frame_edge) begin
                    arm_cnt_nxt = arm_cnt + 1'b1;
                    if (arm_cnt == AW'(ARM_FRAMES - 1)) begin
                        state_nxt  = RUN;
                        to_cnt_nxt = '0;
                    end
                end
            end
            RUN: begin
                if (!arm) begin
                    state_nxt = DISARMED;
                    out_nxt   = '0;
                end else if (frame_edge) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        out_nxt[i] = slew(out_q[i], sp_q[i]);
                    end
                    // a strobe coinciding with the frame edge keeps the counter cleared
                    if (!spd_vld) begin
                        to_cnt_nxt = to_cnt + 1'b1;
                        if (to_cnt == TW'(TIMEOUT_FRAMES - 1)) begin
                            state_nxt = FAILSAFE;
                            out_nxt   = '0;
                        end
                    end
                end
            end
            FAILSAFE: begin
                out_nxt = '0;
                if (!arm) begin
                    state_nxt = DISARMED;
                end
            end
            default: begin
                state_nxt = DISARMED;
                out_nxt   = '0;
            end
        endcase
    end

    assign frnt_out = out_q[0];
    assign bck_out  = out_q[1];
    assign lft_out  = out_q[2];
    assign rght_out = out_q[3];
    assign armed    = (state == RUN);
    assign failsafe = (state == FAILSAFE);

endmodule
